// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults, divisor type and channel-index width helper for the divider bank
package clk_div_pkg;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_DIV = 60;
  typedef logic [DEF_CNT_W-1:0] div_t;
  function automatic int ch_idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel producing a 50% duty sclk and a tick on every toggle
module clk_div_channel #(
  parameter int CNT_W = 16,
  parameter int DEFAULT_DIV = 60
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             sclk,
  output logic             tick,
  output logic             pend
);
  logic [CNT_W-1:0] cnt, div, pdiv;
  logic tc;
  // cnt never exceeds div, so cnt + 1 cannot wrap even at the all-ones divisor
  assign tc = cnt == div;
  // counting, idle/restart and divisor update; a stopped channel takes new divisors directly
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      div <= CNT_W'(DEFAULT_DIV);
      pdiv <= '0;
      pend <= 1'b0;
      sclk <= 1'b0;
      tick <= 1'b0;
    end else if (!en || restart) begin
      cnt <= '0;
      sclk <= 1'b0;
      tick <= 1'b0;
      pend <= 1'b0;
      div <= load ? load_div : pend ? pdiv : div;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      sclk <= sclk ^ tc;
      tick <= tc;
      if (tc && pend) div <= pdiv;
      pend <= load | (pend & ~tc);
      if (load) pdiv <= load_div;
    end
endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH independent programmable clock dividers with a valid/ready divisor port
module clk_div_bank import clk_div_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV,
  localparam int CH_W = ch_idx_w(NUM_CH)
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] restart,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] sclk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);
  // ready only for an in-range channel with no update outstanding
  always_comb begin
    cfg_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (cfg_ch == CH_W'(i)) cfg_ready = !pend[i];
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic load;
    assign load = cfg_valid && cfg_ready && cfg_ch == CH_W'(g);
    clk_div_channel #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clock(clock),
      .rst_n(rst_n),
      .en(ch_en[g]),
      .restart(restart[g]),
      .load(load),
      .load_div(cfg_div),
      .sclk(sclk[g]),
      .tick(tick[g]),
      .pend(pend[g])
    );
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed checks of divider timing, config handshake, restart and async reset
module tb_clk_div_bank;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] ch_en = '0, restart = '0, sclk, tick, pend;
  logic cfg_valid = 1'b0, cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [15:0] cfg_div = '0;
  logic [2:0] ch_en3 = '0, sclk3, tick3, pend3;
  logic cfg_valid3 = 1'b0, cfg_ready3;
  logic [1:0] cfg_ch3 = 2'd2;
  int tests = 0, fails = 0;

  always #5 clock = ~clock;

  clk_div_bank dut (
    .clock(clock), .rst_n(rst_n), .ch_en(ch_en), .restart(restart),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .sclk(sclk), .tick(tick), .pend(pend)
  );

  clk_div_bank #(.NUM_CH(3)) dut3 (
    .clock(clock), .rst_n(rst_n), .ch_en(ch_en3), .restart(3'b000),
    .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3), .cfg_ch(cfg_ch3), .cfg_div(16'd1),
    .sclk(sclk3), .tick(tick3), .pend(pend3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #1;
    check("rst_sclk", sclk, 0);
    check("rst_tick", tick, 0);
    check("rst_pend", pend, 0);
    check("rst_ready", cfg_ready, 1);
    check("n3_ready_ch2", cfg_ready3, 1);
    cfg_ch3 = 2'd3;
    cfg_valid3 = 1'b1;
    #1;
    check("n3_ready_ch3", cfg_ready3, 0);
    step(2);
    rst_n = 1'b1;
    ch_en = 4'hF;
    ch_en3 = 3'b111;
    step(60);
    check("e60_sclk", sclk, 0);
    check("e60_tick", tick, 0);
    step(1);
    check("e61_sclk", sclk, 4'hF);
    check("e61_tick", tick, 4'hF);
    check("n3_e61_tick", tick3, 3'b111);
    check("n3_e61_pend", pend3, 0);
    step(1);
    check("e62_tick", tick, 0);
    check("e62_sclk", sclk, 4'hF);
    step(59);
    check("e121_sclk", sclk, 4'hF);
    step(1);
    check("e122_sclk", sclk, 0);
    check("e122_tick", tick, 4'hF);
    check("e122_pend", pend, 0);
    step(20);
    cfg_ch = 2'd1;
    cfg_div = 16'd9;
    cfg_valid = 1'b1;
    #1;
    check("wr1_ready", cfg_ready, 1);
    step(1);
    check("wr1_pend", pend, 4'b0010);
    check("wr1_ready_low", cfg_ready, 0);
    cfg_div = 16'd3;
    step(1);
    check("wr1_stall_pend", pend, 4'b0010);
    check("wr1_stall_ready", cfg_ready, 0);
    cfg_valid = 1'b0;
    step(38);
    check("e182_pend", pend, 4'b0010);
    check("e182_tick", tick, 0);
    step(1);
    check("e183_pend", pend, 0);
    check("e183_tick", tick, 4'hF);
    check("e183_sclk", sclk, 4'hF);
    step(9);
    check("e192_tick1", tick[1], 0);
    step(1);
    check("e193_tick1", tick[1], 1);
    check("e193_sclk1", sclk[1], 0);
    step(10);
    check("e203_tick1", tick[1], 1);
    check("e203_ready1", cfg_ready, 1);
    ch_en[2] = 1'b0;
    step(1);
    check("dis2_sclk", sclk[2], 0);
    check("dis2_tick", tick[2], 0);
    cfg_ch = 2'd2;
    cfg_div = 16'd0;
    cfg_valid = 1'b1;
    #1;
    check("wr2_ready", cfg_ready, 1);
    step(1);
    check("wr2_pend", pend[2], 0);
    cfg_valid = 1'b0;
    ch_en[2] = 1'b1;
    step(1);
    check("d0_c1", {sclk[2], tick[2]}, 2'b11);
    step(1);
    check("d0_c2", {sclk[2], tick[2]}, 2'b01);
    step(1);
    check("d0_c3", {sclk[2], tick[2], pend[2]}, 3'b110);
    cfg_ch = 2'd0;
    cfg_div = 16'd4;
    cfg_valid = 1'b1;
    step(1);
    check("wr0_pend", pend[0], 1);
    cfg_valid = 1'b0;
    step(34);
    check("e243_ch0", {sclk[0], tick[0]}, 2'b10);
    restart = 4'b0001;
    step(1);
    restart = '0;
    check("rs_tick0", tick[0], 0);
    check("rs_sclk0", sclk[0], 0);
    check("rs_pend0", pend[0], 0);
    check("rs_tick3", tick[3], 1);
    step(4);
    check("rs4_ch0", {sclk[0], tick[0]}, 2'b00);
    step(1);
    check("rs5_ch0", {sclk[0], tick[0]}, 2'b11);
    cfg_ch = 2'd3;
    cfg_div = 16'd7;
    cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    step(3);
    check("pre_rst_pend3", pend[3], 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sclk", sclk, 0);
    check("arst_tick", tick, 0);
    check("arst_pend", pend, 0);
    check("arst_ready", cfg_ready, 1);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    step(60);
    check("post_e60_tick", tick, 0);
    check("post_e60_sclk", sclk, 0);
    step(1);
    check("post_e61_tick", tick, 4'hF);
    check("post_e61_sclk", sclk, 4'hF);
    check("n3_end_ready", cfg_ready3, 0);
    check("n3_end_pend", pend3, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised, multi-channel successor to the single fixed-ratio clock divider. It generates NUM_CH independent divided clock-enables from one fast clock, each with a runtime-programmable divisor, per-channel enable and restart. Each channel produces a 50%-duty `sclk` square wave plus a one-cycle `tick` strobe. Divisor updates go through a valid/ready handshake and apply glitch-free at a period boundary. The bank feeds the debouncers, the matrix scan and future audio/animation timers.

## Interface
- `NUM_CH`, default 4: number of divider channels (1..16).
- `CNT_W`, default 16: width of the divisor and counter.
- `DEFAULT_DIV`, default 60: divisor loaded into every channel at reset.
- `clock`  in  1: single system clock; all logic on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ch_en`  in  NUM_CH: per-channel run enable.
- `restart`  in  NUM_CH: per-channel synchronous restart pulse.
- `cfg_valid`  in  1: divisor write request.
- `cfg_ready`  out  1: write can be accepted this cycle.
- `cfg_ch`  in  $clog2(NUM_CH) (min 1): target channel.
- `cfg_div`  in  CNT_W: new divisor D.
- `sclk`  out  NUM_CH: divided square wave, registered.
- `tick`  out  NUM_CH: one-cycle strobe on each `sclk` toggle, registered.
- `pend`  out  NUM_CH: divisor update pending per channel.

## Operation
- Per channel state:
  - counter `cnt` (CNT_W)
  - active divisor `div`
  - pending divisor `pdiv` with flag `pend`
  - `sclk` register and `tick` register
- Counting, when `ch_en`=1:
  - Each edge: if `cnt`==`div`, then `cnt`←0, `sclk` toggles, `tick`←1. Otherwise `cnt`←`cnt`+1 and `tick`←0.
  - Half-period is D+1 cycles; full period is 2(D+1).
  - D=0 gives `sclk` at clock/2 with `tick` high every cycle.
  - D=2^CNT_W−1 is legal and must not overflow.
- Disabled (`ch_en`=0):
  - `cnt`←0, `sclk`←0, `tick`←0.
  - A pending divisor is applied immediately (`div`←`pdiv`, `pend`←0).
  - Re-enabling starts a fresh period from `cnt`=0, `sclk`=0.
- Restart (`restart`[i]=1):
  - Same effect as one disabled cycle: `cnt`←0, `sclk`←0, `tick`←0, pending applied.
  - Restart takes priority over the terminal count; no tick is produced that cycle.
- Config handshake:
  - `cfg_ready` = (`cfg_ch` < NUM_CH) and `pend`[`cfg_ch`]=0. It is combinational from `cfg_ch` and registered `pend`.
  - A transfer occurs when `cfg_valid` and `cfg_ready` are both high at a rising edge.
  - On transfer to an enabled channel with no restart that cycle: `pdiv`←`cfg_div`, `pend`←1. The new divisor becomes `div` on that channel's next terminal-count edge, at the same edge `cnt`→0. That edge still uses the old `div` for its own comparison.
  - On transfer to a disabled or restarting channel: `div`←`cfg_div` directly; `pend` stays 0.
  - If a transfer and a terminal count hit the same channel on the same edge, the data goes pending and applies at the following terminal count.
  - An out-of-range `cfg_ch` holds `cfg_ready` low; the request is never accepted.
- Reset values (async assertion of `rst_n`): all `cnt`=0, `div`=DEFAULT_DIV, `pdiv`=0, `pend`=0, `sclk`=0, `tick`=0.
- While `rst_n` is asserted, `cfg_ready` is still a combinational function of `cfg_ch` and `pend` (=0), but no transfer occurs.
- Reset release mid-period simply restarts every channel from zero.

## Timing
- `sclk` and `tick` are registered and change on the same edge.
- With `ch_en`=1 from the first edge after reset release and D=60:
  - `sclk` rises after edge 61 (counting the first enabled edge as edge 1) and falls after edge 122.
  - `tick` is high in the 61st and 122nd cycles.
- Config latency:
  - Disabled channel: one edge from accept to `div` update.
  - Enabled channel: the next terminal count, at most D_old+1 edges.
- `pend` rises the edge after accept and clears on the apply edge.
- `cfg_ready` can reassert in the cycle after `pend` clears.
- Channels are fully independent; no cross-channel timing relation is guaranteed except a common restart edge.

## Structure
- Package `clk_div_pkg` holds:
  - `DEFAULT_DIV` and default `CNT_W`
  - `typedef logic [CNT_W-1:0] div_t`
  - channel-index width helper
- Sub-module `clk_div_channel`: one channel holding `cnt`/`div`/`pdiv`/`pend`/`sclk`/`tick`.
  - Inputs: `en`, `restart`, `load`, `load_div`.
  - `clk_div_bank` generates NUM_CH instances and decodes the handshake into per-channel `load`.

## Test plan
- Reset, all `ch_en`=1, D=60: `sclk`[i] period 122 cycles, 50% duty; `tick` pulses 61 cycles apart; `pend`=0, `cfg_ready`=1.
- Enabled ch1 at D=60, write D=9 mid-period: `pend`[1]=1 and `cfg_ready` low for ch1 until the next terminal count. After that the half-period is 10 cycles. A second write while pending stalls.
- Disabled ch2, write D=0, then enable: `sclk`[2] toggles every cycle and `tick`[2] is held high; `pend`[2] never sets.
- Ch0 `restart` on its terminal-count cycle: no tick; `sclk`[0]=0 and `cnt`=0 next cycle; a pending divisor applies there.
- NUM_CH=3, `cfg_ch`=3 with `cfg_valid`=1: `cfg_ready`=0 indefinitely and no channel changes.
- `rst_n` pulsed low asynchronously mid-period with `pend` set: all outputs 0 immediately, `div` back to 60, `pend` cleared.
